bank64k_arbiter: RTL and testbench

- Shares one 64-bit x 1024 data bank between three requesters: index 0 = interconnect (i), 1 = data (d), 2 = compute (c).
- Two independent round-robin arbiters: one for the bank's write port, one for its read port.
- Drives the bank's enable, address and muxcode controls directly.
- Returns a one-hot read-valid to the requester that owns the data as it leaves the BRAM.
- Does not touch data words: write data is steered by the bank's own mux; read data is broadcast by the bank.

---
 rtl/bank64k_arbiter.sv | 157 +++++++++++++++
 tb/tb_bank64k_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bank64k_arbiter.sv
// Write/read round-robin arbiter for one shared 64-bit x 1024 BRAM bank.
// Define BANK_ARB_COLL_STALL_EN to stall reads that hit the address being written.
module bank64k_arbiter #(
    parameter int A     = 10,
    parameter int RDLAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2:0]     wr_req,
    input  logic [2:0]     wr_lock,
    input  logic [3*A-1:0] wr_addr,
    output logic [2:0]     wr_gnt,
    input  logic [2:0]     rd_req,
    input  logic [3*A-1:0] rd_addr,
    output logic [2:0]     rd_gnt,
    output logic [2:0]     rd_vld,
    output logic           bank_wr_en,
    output logic [A-1:0]   bank_wr_addr,
    output logic [1:0]     bank_wr_muxcode,
    output logic           bank_rd_en,
    output logic [A-1:0]   bank_rd_addr,
    output logic [1:0]     bank_rd_muxcode
);

    function automatic logic [2:0] rr_pick(input logic [2:0] req,
                                           input logic [1:0] ptr);
        logic [2:0] g;
        int         j;
        g = '0;
        for (int i = 0; i < 3; i++) begin
            j = (int'(ptr) + i) % 3;
            if (g == 3'b000 && req[j]) g[j] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [1:0] oh2idx(input logic [2:0] g);
        logic [1:0] k;
        k = 2'd0;
        if (g[1]) k = 2'd1;
        if (g[2]) k = 2'd2;
        return k;
    endfunction

    function automatic logic [1:0] ptr_after(input logic [1:0] k);
        return (k == 2'd2) ? 2'd0 : k + 2'd1;
    endfunction

    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic       wr_own_vld_q, wr_own_vld_d;
    logic [1:0] wr_own_q, wr_own_d;

    logic       pv_q [RDLAT];
    logic [1:0] pi_q [RDLAT];

    logic [2:0]   wr_gnt_c;
    logic [1:0]   wr_idx;
    logic [2:0]   rd_win;
    logic [1:0]   rd_idx;
    logic [A-1:0] rd_win_addr;
    logic         coll;

    // A locked owner keeps the port only while it still requests with lock.
    always_comb begin
        wr_gnt_c = rr_pick(wr_req, wr_ptr_q);
        if (wr_own_vld_q && wr_req[wr_own_q] && wr_lock[wr_own_q])
            wr_gnt_c = 3'b001 << wr_own_q;
        if (rst) wr_gnt_c = '0;
    end

    assign wr_idx = oh2idx(wr_gnt_c);

    always_comb begin
        bank_wr_en      = |wr_gnt_c;
        bank_wr_addr    = '0;
        bank_wr_muxcode = 2'b00;
        if (bank_wr_en) begin
            bank_wr_addr    = wr_addr[int'(wr_idx)*A +: A];
            bank_wr_muxcode = wr_idx;
        end
    end

    always_comb begin
        rd_win = rr_pick(rd_req, rd_ptr_q);
        if (rst) rd_win = '0;
    end

    assign rd_idx      = oh2idx(rd_win);
    assign rd_win_addr = rd_addr[int'(rd_idx)*A +: A];

`ifdef BANK_ARB_COLL_STALL_EN
    assign coll = bank_wr_en && (|rd_win) && (rd_win_addr == bank_wr_addr);
`else
    assign coll = 1'b0;
`endif

    always_comb begin
        rd_gnt          = coll ? 3'b000 : rd_win;
        bank_rd_en      = |rd_gnt;
        bank_rd_addr    = '0;
        bank_rd_muxcode = 2'b00;
        if (bank_rd_en) begin
            bank_rd_addr    = rd_win_addr;
            bank_rd_muxcode = rd_idx;
        end
    end

    assign wr_gnt = wr_gnt_c;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        wr_own_vld_d = 1'b0;
        wr_own_d     = wr_own_q;
        rd_ptr_d     = rd_ptr_q;
        if (bank_wr_en) begin
            wr_ptr_d     = ptr_after(wr_idx);
            wr_own_vld_d = wr_lock[wr_idx];
            wr_own_d     = wr_idx;
        end
        if (bank_rd_en) rd_ptr_d = ptr_after(rd_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            wr_own_vld_q <= 1'b0;
            wr_own_q     <= 2'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_own_vld_q <= wr_own_vld_d;
            wr_own_q     <= wr_own_d;
        end
    end

    // {valid, idx} delay line matching the BRAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RDLAT; i++) begin
                pv_q[i] <= 1'b0;
                pi_q[i] <= 2'd0;
            end
        end else begin
            pv_q[0] <= bank_rd_en;
            pi_q[0] <= rd_idx;
            for (int i = 1; i < RDLAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pi_q[i] <= pi_q[i-1];
            end
        end
    end

    assign rd_vld = pv_q[RDLAT-1] ? (3'b001 << pi_q[RDLAT-1]) : 3'b000;

endmodule

// File: tb/tb_bank64k_arbiter.sv
// Directed bench for bank64k_arbiter: RDLAT=1 and RDLAT=2 instances share stimulus.
// A small BRAM model on the RDLAT=1 instance checks collision read data.
module tb_bank64k_arbiter;

    localparam int A = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    wr_req, wr_lock, rd_req;
    logic [3*A-1:0] wr_addr, rd_addr;

    logic [2:0]   wr_gnt, rd_gnt, rd_vld;
    logic         bwe, bre;
    logic [A-1:0] bwa, bra;
    logic [1:0]   bwm, brm;

    logic [2:0]   wr_gnt2, rd_gnt2, rd_vld2;
    logic         bwe2, bre2;
    logic [A-1:0] bwa2, bra2;
    logic [1:0]   bwm2, brm2;

    logic [63:0] wdata [3];
    logic [63:0] mem [1024];
    logic [63:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bank64k_arbiter #(.A(A), .RDLAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_lock(wr_lock), .wr_addr(wr_addr),
        .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_gnt(rd_gnt), .rd_vld(rd_vld),
        .bank_wr_en(bwe), .bank_wr_addr(bwa), .bank_wr_muxcode(bwm),
        .bank_rd_en(bre), .bank_rd_addr(bra), .bank_rd_muxcode(brm)
    );

    bank64k_arbiter #(.A(A), .RDLAT(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_lock(wr_lock), .wr_addr(wr_addr),
        .wr_gnt(wr_gnt2),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_gnt(rd_gnt2), .rd_vld(rd_vld2),
        .bank_wr_en(bwe2), .bank_wr_addr(bwa2), .bank_wr_muxcode(bwm2),
        .bank_rd_en(bre2), .bank_rd_addr(bra2), .bank_rd_muxcode(brm2)
    );

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
    end

    always @(posedge clk) begin
        if (bwe) mem[bwa] <= wdata[bwm];
        if (bre) rdata <= mem[bra];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_g [6];
    logic [1:0] exp_m [6];

    initial begin
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_m = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        wdata[0] = 64'h1111_0000_0000_0000;
        wdata[1] = 64'h2222_0000_0000_0000;
        wdata[2] = 64'h3333_0000_0000_0000;

        // reset with requests pending: everything forced low
        rst = 1'b1;
        wr_req = 3'b111; wr_lock = 3'b000; rd_req = 3'b111;
        wr_addr = '0; rd_addr = '0;
        #1;
        chk("rst_wr_gnt", 64'(wr_gnt), 64'(3'b000));
        chk("rst_rd_gnt", 64'(rd_gnt), 64'(3'b000));
        chk("rst_bank_en", 64'({bwe, bre}), 64'(2'b00));

        nxt();
        rst = 1'b0; wr_req = '0; rd_req = '0;
        #1;
        chk("idle_rd_vld", 64'(rd_vld), 64'(3'b000));
        chk("idle_en", 64'({bwe, bre, bwa, bwm}), 64'(0));

        // write round-robin rotation
        for (int i = 0; i < 6; i++) begin
            nxt();
            wr_req = 3'b111;
            #1;
            chk($sformatf("rr_wr_gnt%0d", i), 64'(wr_gnt), 64'(exp_g[i]));
            chk($sformatf("rr_wr_mux%0d", i), 64'(bwm), 64'(exp_m[i]));
        end

        // single read from requester d
        nxt();
        wr_req = '0;
        rd_req = 3'b010;
        rd_addr[A +: A] = 10'h155;
        #1;
        chk("rd_gnt_d", 64'(rd_gnt), 64'(3'b010));
        chk("rd_bank", 64'({bre, bra, brm}), 64'({1'b1, 10'h155, 2'b01}));
        chk("rd_vld_n", 64'(rd_vld), 64'(3'b000));
        nxt();
        rd_req = '0;
        #1;
        chk("rd_vld_n1", 64'(rd_vld), 64'(3'b010));
        chk("rd_vld2_n1", 64'(rd_vld2), 64'(3'b000));
        nxt();
        #1;
        chk("rd_vld_n2", 64'(rd_vld), 64'(3'b000));
        chk("rd_vld2_n2", 64'(rd_vld2), 64'(3'b010));

        // burst lock held by requester 2
        nxt();
        wr_req = 3'b100; wr_lock = 3'b100;
        #1;
        chk("lock_c1", 64'(wr_gnt), 64'(3'b100));
        for (int i = 2; i <= 4; i++) begin
            nxt();
            wr_req = 3'b111;
            #1;
            chk($sformatf("lock_c%0d", i), 64'(wr_gnt), 64'(3'b100));
        end
        nxt();
        wr_lock = 3'b000;
        #1;
        chk("lock_drop", 64'(wr_gnt), 64'(3'b001));

        // read in flight when reset arrives
        nxt();
        wr_req = '0;
        rd_req = 3'b001;
        #1;
        chk("rst_rd_gnt_n", 64'(rd_gnt), 64'(3'b001));
        nxt();
        rst = 1'b1; rd_req = 3'b111; wr_req = 3'b111;
        #1;
        chk("rst_gnt_forced", 64'({wr_gnt, rd_gnt, bwe, bre}), 64'(0));
        chk("rst_vld1_n1", 64'(rd_vld), 64'(3'b001));
        nxt();
        rst = 1'b0;
        #1;
        chk("rst_vld2_dropped", 64'(rd_vld2), 64'(3'b000));
        chk("post_rst_wr", 64'(wr_gnt), 64'(3'b001));
        chk("post_rst_rd", 64'(rd_gnt), 64'(3'b001));
        nxt();
        wr_req = '0; rd_req = '0;
        #1;
        chk("rst_vld2_n3", 64'(rd_vld2), 64'(3'b000));

        // same-address write and read of 0x3FF
        nxt();
        wr_req = 3'b001; wr_addr[0 +: A] = 10'h3FF;
        rd_req = 3'b010; rd_addr[A +: A] = 10'h3FF;
        #1;
        chk("coll_wr_gnt", 64'(wr_gnt), 64'(3'b001));
        chk("coll_wr_addr", 64'(bwa), 64'(10'h3FF));
`ifdef BANK_ARB_COLL_STALL_EN
        chk("coll_rd_stall", 64'({rd_gnt, bre}), 64'(0));
        nxt();
        wr_req = '0;
        #1;
        chk("coll_rd_retry", 64'(rd_gnt), 64'(3'b010));
        chk("coll_rd_addr", 64'(bra), 64'(10'h3FF));
        nxt();
        rd_req = '0;
        #1;
        chk("coll_rd_vld", 64'(rd_vld), 64'(3'b010));
        chk("coll_rd_data", rdata, wdata[0]);
`else
        chk("coll_both_gnt", 64'(rd_gnt), 64'(3'b010));
        chk("coll_both_en", 64'({bwe, bre}), 64'(2'b11));
        nxt();
        wr_req = '0; rd_req = '0;
        #1;
        chk("coll_rd_vld", 64'(rd_vld), 64'(3'b010));
`endif

        nxt();
        wr_req = '0; rd_req = '0;
        #1;
        chk("final_idle", 64'({wr_gnt, rd_gnt, rd_vld, bwe, bre}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
